// File: rtl/digi_ota_array.sv
// Array of digitally modelled comparator/OTA channels: each channel synchronises a
// differential pair, glitch-filters the decision and drives a keeper-capable output.
module digi_ota_array #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     vip,
    input  logic [CH-1:0]     vin,
    input  logic [CH-1:0]     en,
    input  logic              mode,
    input  logic [FILT_W-1:0] filt_len,
    output logic [CH-1:0]     out,
    output logic [CH-1:0]     oe,
    output logic [CH-1:0]     evt,
    output logic [CH-1:0]     cm
);

    typedef enum logic [1:0] {StOff, StCm, StUp, StDn} state_e;

    localparam logic [FILT_W-1:0] CntMax = {FILT_W{1'b1}};

    logic [CH-1:0]     sp_q [SYNC_STAGES];
    logic [CH-1:0]     sn_q [SYNC_STAGES];
    logic [CH-1:0]     sp;
    logic [CH-1:0]     sn;

    state_e            state_q [CH];
    state_e            state_d [CH];
    state_e            cand_q  [CH];
    state_e            cand_d  [CH];
    logic [FILT_W-1:0] cnt_q   [CH];
    logic [FILT_W-1:0] cnt_d   [CH];
    logic [CH-1:0]     out_q;
    logic [CH-1:0]     out_d;
    logic [CH-1:0]     evt_q;
    logic [CH-1:0]     evt_d;

    function automatic state_e classify(input logic p, input logic n);
        if (p && !n) return StUp;
        if (!p && n) return StDn;
        return StCm;
    endfunction

    // Synchronisers run regardless of enable so re-enabled channels see settled data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sp_q[k] <= '0;
                sn_q[k] <= '0;
            end
        end else begin
            sp_q[0] <= vip;
            sn_q[0] <= vin;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sp_q[k] <= sp_q[k-1];
                sn_q[k] <= sn_q[k-1];
            end
        end
    end

    assign sp = sp_q[SYNC_STAGES-1];
    assign sn = sn_q[SYNC_STAGES-1];

    always_comb begin
        for (int i = 0; i < int'(CH); i++) begin
            state_d[i] = state_q[i];
            cand_d[i]  = cand_q[i];
            cnt_d[i]   = cnt_q[i];
            out_d[i]   = out_q[i];

            if (!en[i]) begin
                state_d[i] = StOff;
                cand_d[i]  = StCm;
                cnt_d[i]   = '0;
                out_d[i]   = 1'b0;
            end else if (state_q[i] == StOff) begin
                // Enable edge: park in CM and start qualification from scratch.
                state_d[i] = StCm;
                cand_d[i]  = StCm;
                cnt_d[i]   = '0;
            end else begin
                if (classify(sp[i], sn[i]) == cand_q[i]) begin
                    cnt_d[i] = (cnt_q[i] == CntMax) ? cnt_q[i] : cnt_q[i] + 1'b1;
                end else begin
                    cand_d[i] = classify(sp[i], sn[i]);
                    cnt_d[i]  = '0;
                end
                // cnt_d counts equal samples beyond the first, so this needs filt_len+1.
                if (cnt_d[i] >= filt_len) begin
                    state_d[i] = cand_d[i];
                end
                unique case (state_d[i])
                    StUp:    out_d[i] = 1'b1;
                    StDn:    out_d[i] = 1'b0;
                    default: out_d[i] = out_q[i];
                endcase
            end

            evt_d[i] = out_d[i] ^ out_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CH); i++) begin
                state_q[i] <= StOff;
                cand_q[i]  <= StCm;
                cnt_q[i]   <= '0;
            end
            out_q <= '0;
            evt_q <= '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                state_q[i] <= state_d[i];
                cand_q[i]  <= cand_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out_q <= out_d;
            evt_q <= evt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(CH); i++) begin
            oe[i] = 1'b0;
            cm[i] = 1'b0;
            unique case (state_q[i])
                StUp, StDn: oe[i] = 1'b1;
                StCm: begin
                    oe[i] = mode;
                    cm[i] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out = out_q;
    assign evt = evt_q;

endmodule

// File: tb/tb_digi_ota_array.sv
// Randomised plus directed bench for digi_ota_array; a behavioural channel model feeds
// a scoreboard queue that a negedge monitor drains and compares.
module tb_digi_ota_array;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] vip, vin, en, out, oe, evt, cm;
    logic          mode;
    logic [FW-1:0] filt_len;

    digi_ota_array #(.CH(CH), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
        .clk(clk), .rst(rst), .vip(vip), .vin(vin), .en(en), .mode(mode),
        .filt_len(filt_len), .out(out), .oe(oe), .evt(evt), .cm(cm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] out;
        logic [CH-1:0] oe;
        logic [CH-1:0] evt;
        logic [CH-1:0] cm;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: 0 = off, 1 = common-mode, 2 = up, 3 = down.
    logic [2*CH-1:0] syncq[$];
    int              ms[CH];
    int              rc[CH];
    int              run[CH];
    bit              mo[CH];

    function automatic int cls(input bit p, input bit n);
        if (p && !n) return 2;
        if (!p && n) return 3;
        return 1;
    endfunction

    function automatic exp_t model(input bit r, input logic [CH-1:0] e, input bit m,
                                   input int fl, input logic [CH-1:0] p,
                                   input logic [CH-1:0] n);
        exp_t            x;
        logic [2*CH-1:0] seen;
        bit              prev;
        int              c;
        x = '0;
        if (r) begin
            syncq.delete();
            repeat (SS) syncq.push_back('0);
            for (int i = 0; i < CH; i++) begin
                ms[i] = 0; rc[i] = 1; run[i] = 0; mo[i] = 0;
            end
            return x;
        end
        seen = syncq.pop_front();
        syncq.push_back({p, n});
        for (int i = 0; i < CH; i++) begin
            prev = mo[i];
            c    = cls(seen[CH+i], seen[i]);
            if (!e[i]) begin
                ms[i] = 0; rc[i] = 1; run[i] = 0; mo[i] = 0;
            end else if (ms[i] == 0) begin
                ms[i] = 1; rc[i] = 1; run[i] = 0;
            end else begin
                if (c == rc[i]) run[i] = (run[i] < 1000) ? run[i] + 1 : run[i];
                else begin
                    rc[i] = c; run[i] = 1;
                end
                if (run[i] >= fl + 1) ms[i] = rc[i];
                if (ms[i] == 2) mo[i] = 1;
                else if (ms[i] == 3) mo[i] = 0;
            end
            x.out[i] = mo[i];
            x.evt[i] = (mo[i] != prev);
            x.oe[i]  = (ms[i] >= 2) || (ms[i] == 1 && m);
            x.cm[i]  = (ms[i] == 1);
        end
        return x;
    endfunction

    task automatic cmp(input string name, input logic [CH-1:0] got, input logic [CH-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
        end
    endtask

    // Drive one cycle's inputs, predict the result of the next edge, return at the negedge.
    task automatic step(input bit r, input logic [CH-1:0] e, input bit m, input int fl,
                        input logic [CH-1:0] p, input logic [CH-1:0] n);
        #1;
        rst = r; en = e; mode = m; filt_len = FW'(fl); vip = p; vin = n;
        expq.push_back(model(r, e, m, fl, p, n));
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                x = expq.pop_front();
                cmp("out", out, x.out);
                cmp("oe",  oe,  x.oe);
                cmp("evt", evt, x.evt);
                cmp("cm",  cm,  x.cm);
            end
        end
    end

    initial begin : stim
        logic [CH-1:0] p, n, e;
        bit            m;
        int            fl;

        // Reset state.
        step(1, 4'b1111, 0, 0, 4'b0000, 4'b0000);
        cmp("reset_out", out, 4'b0000);
        cmp("reset_oe",  oe,  4'b0000);

        // Single UP on ch0 with filt_len=0: edge 3 after release.
        step(0, 4'b1111, 0, 0, 4'b0001, 4'b0000);
        step(0, 4'b1111, 0, 0, 4'b0001, 4'b0000);
        cmp("ch0_not_yet", out, 4'b0000);
        step(0, 4'b1111, 0, 0, 4'b0001, 4'b0000);
        cmp("ch0_up_out", out, 4'b0001);
        cmp("ch0_up_evt", evt, 4'b0001);
        cmp("ch0_up_oe",  oe,  4'b0001);
        cmp("ch0_up_cm",  cm,  4'b1110);
        step(0, 4'b1111, 0, 0, 4'b0001, 4'b0000);
        cmp("ch0_evt_once", evt, 4'b0000);

        // ch0 to DN, then glitches to UP with filt_len=3.
        repeat (6) step(0, 4'b1111, 0, 3, 4'b0000, 4'b0001);
        cmp("ch0_dn", out, 4'b0000);
        repeat (3) step(0, 4'b1111, 0, 3, 4'b0001, 4'b0000);
        repeat (6) step(0, 4'b1111, 0, 3, 4'b0000, 4'b0001);
        cmp("glitch3_ignored", out, 4'b0000);
        repeat (5) step(0, 4'b1111, 0, 3, 4'b0001, 4'b0000);
        cmp("glitch4_pending", out, 4'b0000);
        step(0, 4'b1111, 0, 3, 4'b0001, 4'b0000);
        cmp("glitch4_accept", out, 4'b0001);

        // ch1 and ch2 UP, then ch1 common-mode hold under both modes.
        repeat (4) step(0, 4'b1111, 0, 0, 4'b0111, 4'b0000);
        repeat (4) step(0, 4'b1111, 0, 0, 4'b0111, 4'b0010);
        cmp("ch1_cm_hold", out & 4'b0010, 4'b0010);
        cmp("ch1_cm_oe0",  oe  & 4'b0010, 4'b0000);
        step(0, 4'b1111, 1, 0, 4'b0111, 4'b0010);
        cmp("ch1_cm_oe1",  oe  & 4'b0010, 4'b0010);
        cmp("ch1_cm_noevt", evt, 4'b0000);

        // Disable ch2 while UP, then re-enable.
        step(0, 4'b1011, 0, 0, 4'b0111, 4'b0010);
        cmp("ch2_off_evt", evt & 4'b0100, 4'b0100);
        repeat (3) step(0, 4'b1111, 0, 0, 4'b0111, 4'b0010);

        // Reset mid-qualification with ch3 changing.
        step(0, 4'b1111, 0, 3, 4'b1110, 4'b0001);
        step(0, 4'b1111, 0, 3, 4'b1110, 4'b0001);
        step(0, 4'b1111, 0, 3, 4'b0110, 4'b1001);
        step(1, 4'b1111, 0, 3, 4'b1110, 4'b0001);
        cmp("rst_mid_evt", evt, 4'b0000);
        repeat (6) step(0, 4'b1111, 0, 0, 4'b1111, 4'b0000);

        // All channels UP -> DN on the same edge.
        repeat (2) step(0, 4'b1111, 0, 0, 4'b0000, 4'b1111);
        step(0, 4'b1111, 0, 0, 4'b0000, 4'b1111);
        cmp("all_dn_evt", evt, 4'b1111);
        cmp("all_dn_out", out, 4'b0000);
        cmp("all_dn_oe",  oe,  4'b1111);
        step(0, 4'b1111, 0, 0, 4'b0000, 4'b1111);
        cmp("all_dn_evt_once", evt, 4'b0000);

        // Randomised phase with sticky inputs so decisions qualify.
        p = '0; n = '0; e = 4'b1111; m = 0; fl = 1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(3) == 0) p[i] = ~p[i];
                if ($urandom_range(3) == 0) n[i] = ~n[i];
                if ($urandom_range(40) == 0) e[i] = ~e[i];
            end
            if ($urandom_range(15) == 0) m = ~m;
            if ($urandom_range(20) == 0) fl = $urandom_range(3);
            step($urandom_range(150) == 0, e, m, fl, p, n);
        end

        @(negedge clk);
        cmp("queue_drained", 4'(expq.size()), 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
